// File: rtl/imem_dmem_arbiter.sv
// Shares one 64-bit memory port between instruction fetch and load/store.
// Data has priority, with a starvation guard for fetch and a per-transaction timeout.
module imem_dmem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_flush,
    output logic              i_done,
    output logic [63:0]       i_rdata,
    output logic              i_err,
    output logic              i_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_wstrb,
    output logic              d_done,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              d_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    output logic [7:0]        mem_wstrb,
    input  logic              mem_ack,
    input  logic [63:0]       mem_rdata
);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [SW-1:0] starve_cnt;
    logic [7:0]    tmo_cnt;
    logic          discard;
    logic          d_lane;
    logic          grant_d, grant_i, tmo_hit, fetch_keep;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^{i_addr[2:0], d_addr[1:0]};

    assign i_stall = i_req & ~i_done;
    assign d_stall = d_req & ~d_done;

    always_comb begin
        grant_d    = 1'b0;
        grant_i    = 1'b0;
        tmo_hit    = 1'b0;
        state_nx   = state;
        // A flush in the ack cycle itself also kills the fetch result.
        fetch_keep = ~(discard | i_flush);
        case (state)
            IDLE: begin
                grant_d = d_req & ~(i_req & (starve_cnt == SW'(STARVE_MAX)));
                grant_i = ~grant_d & i_req;
                if (grant_d)
                    state_nx = BUSY_D;
                else if (grant_i)
                    state_nx = BUSY_I;
            end
            BUSY_I, BUSY_D: begin
                tmo_hit = ~mem_ack & (tmo_cnt == 8'(TIMEOUT));
                if (mem_ack | tmo_hit)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            tmo_cnt    <= '0;
            discard    <= 1'b0;
            d_lane     <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
            i_done     <= 1'b0;
            i_err      <= 1'b0;
            i_rdata    <= '0;
            d_done     <= 1'b0;
            d_err      <= 1'b0;
            d_rdata    <= '0;
        end else begin
            state  <= state_nx;
            i_done <= 1'b0;
            i_err  <= 1'b0;
            d_done <= 1'b0;
            d_err  <= 1'b0;
            case (state)
                IDLE: begin
                    discard <= 1'b0;
                    // Loaded with 1 so tmo_cnt equals the number of BUSY cycles elapsed.
                    tmo_cnt <= (grant_d | grant_i) ? 8'd1 : 8'd0;
                    if (!i_req || grant_i)
                        starve_cnt <= '0;
                    else if (grant_d && starve_cnt != SW'(STARVE_MAX))
                        starve_cnt <= starve_cnt + SW'(1);
                    if (grant_d) begin
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= {d_addr[ADDR_W-1:3], 3'b000};
                        mem_wdata <= {d_wdata, d_wdata};
                        mem_wstrb <= d_addr[2] ? {4'b0000, d_wstrb} : {d_wstrb, 4'b0000};
                        d_lane    <= d_addr[2];
                    end else if (grant_i) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= {i_addr[ADDR_W-1:3], 3'b000};
                        mem_wstrb <= 8'h00;
                    end
                end
                BUSY_I: begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                    discard <= discard | i_flush;
                    if (mem_ack | tmo_hit) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wstrb <= 8'h00;
                        discard   <= 1'b0;
                        if (fetch_keep) begin
                            i_done  <= 1'b1;
                            i_err   <= tmo_hit;
                            i_rdata <= mem_ack ? mem_rdata : 64'd0;
                        end
                    end
                end
                BUSY_D: begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                    if (mem_ack | tmo_hit) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wstrb <= 8'h00;
                        d_done    <= 1'b1;
                        d_err     <= tmo_hit;
                        // Lower address word sits in the upper half of the doubleword.
                        if (mem_ack)
                            d_rdata <= d_lane ? mem_rdata[31:0] : mem_rdata[63:32];
                        else
                            d_rdata <= 32'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter: bus formatting, arbitration order,
// flush discard, timeout boundary and mid-transaction reset.
module tb_imem_dmem_arbiter;
    logic        clk;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_flush;
    logic        i_done;
    logic [63:0] i_rdata;
    logic        i_err;
    logic        i_stall;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        d_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_ack;
    logic [63:0] mem_rdata;

    logic        ack_auto;
    logic        ack_force;
    logic        ack_en;
    int          ack_delay;
    int          wcnt;
    logic [63:0] rdata_val;

    int n_checks;
    int n_fail;

    assign mem_ack   = ack_auto | ack_force;
    assign mem_rdata = rdata_val;

    imem_dmem_arbiter #(
        .ADDR_W(32),
        .STARVE_MAX(4),
        .TIMEOUT(255)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
        .i_done(i_done), .i_rdata(i_rdata), .i_err(i_err), .i_stall(i_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory responder: acks ack_delay cycles after mem_req first goes high.
    initial begin
        ack_auto = 1'b0;
        wcnt = 0;
        forever begin
            @(negedge clk);
            if (mem_req && ack_en) begin
                ack_auto = (wcnt == ack_delay);
                wcnt++;
            end else begin
                ack_auto = 1'b0;
                wcnt = 0;
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({mem_req, mem_we, i_done, d_done, i_err, d_err, i_stall, d_stall} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 00000000",
                     {mem_req, mem_we, i_done, d_done, i_err, d_err, i_stall, d_stall});
        end
        n_checks++;
        if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        n_checks++;
        if (mem_wstrb !== 8'h0) begin n_fail++; $display("FAIL reset_mem_wstrb: got %h want 0", mem_wstrb); end
        n_checks++;
        if (mem_wdata !== 64'h0) begin n_fail++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
        n_checks++;
        if (i_rdata !== 64'h0) begin n_fail++; $display("FAIL reset_i_rdata: got %h want 0", i_rdata); end
        n_checks++;
        if (d_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_d_rdata: got %h want 0", d_rdata); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b0) begin n_fail++; $display("FAIL idle_no_req: got %b want 0", mem_req); end
    endtask

    task automatic test_fetch();
        @(posedge clk); #1;
        ack_en = 1'b1; ack_delay = 0;
        rdata_val = 64'h11111111_22222222;
        i_addr = 32'h1004; i_req = 1'b1;
        @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b0 || i_stall !== 1'b1) begin
            n_fail++; $display("FAIL fetch_cycle0: got req=%b stall=%b want req=0 stall=1", mem_req, i_stall);
        end
        @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0) begin
            n_fail++; $display("FAIL fetch_bus_ctrl: got req=%b we=%b want req=1 we=0", mem_req, mem_we);
        end
        n_checks++;
        if (mem_addr !== 32'h1000) begin n_fail++; $display("FAIL fetch_mem_addr: got %h want 00001000", mem_addr); end
        n_checks++;
        if (mem_wstrb !== 8'h00) begin n_fail++; $display("FAIL fetch_mem_wstrb: got %h want 00", mem_wstrb); end
        @(negedge clk);
        n_checks++;
        if (i_done !== 1'b1 || i_err !== 1'b0 || i_stall !== 1'b0) begin
            n_fail++; $display("FAIL fetch_done: got done=%b err=%b stall=%b want 1 0 0", i_done, i_err, i_stall);
        end
        n_checks++;
        if (i_rdata !== 64'h11111111_22222222) begin
            n_fail++; $display("FAIL fetch_rdata: got %h want 1111111122222222", i_rdata);
        end
        i_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (i_done !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++; $display("FAIL fetch_pulse: got done=%b req=%b want 0 0", i_done, mem_req);
        end
        n_checks++;
        if (i_rdata !== 64'h11111111_22222222) begin
            n_fail++; $display("FAIL fetch_rdata_hold: got %h want 1111111122222222", i_rdata);
        end
    endtask

    task automatic test_data();
        logic [31:0] ra [2];
        logic [63:0] rd [2];
        logic [31:0] rexp [2];
        ra[0] = 32'h2000; rd[0] = 64'hDEADBEEF_00000000; rexp[0] = 32'hDEADBEEF;
        ra[1] = 32'h2004; rd[1] = 64'hDEADBEEF_CAFEF00D; rexp[1] = 32'hCAFEF00D;
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2004; d_wdata = 32'hA5A5A5A5; d_wstrb = 4'b0011;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || d_stall !== 1'b1) begin
            n_fail++; $display("FAIL wr_ctrl: got req=%b we=%b stall=%b want 1 1 1", mem_req, mem_we, d_stall);
        end
        n_checks++;
        if (mem_addr !== 32'h2000) begin n_fail++; $display("FAIL wr_mem_addr: got %h want 00002000", mem_addr); end
        n_checks++;
        if (mem_wstrb !== 8'h03) begin n_fail++; $display("FAIL wr_mem_wstrb: got %h want 03", mem_wstrb); end
        n_checks++;
        if (mem_wdata !== 64'hA5A5A5A5_A5A5A5A5) begin
            n_fail++; $display("FAIL wr_mem_wdata: got %h want a5a5a5a5a5a5a5a5", mem_wdata);
        end
        @(negedge clk);
        n_checks++;
        if (d_done !== 1'b1 || d_err !== 1'b0 || i_done !== 1'b0 || d_stall !== 1'b0) begin
            n_fail++; $display("FAIL wr_done: got done=%b err=%b idone=%b stall=%b want 1 0 0 0",
                               d_done, d_err, i_done, d_stall);
        end
        d_req = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            d_req = 1'b1; d_we = 1'b0; d_addr = ra[k]; rdata_val = rd[k];
            @(negedge clk);
            @(negedge clk);
            n_checks++;
            if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h2000) begin
                n_fail++; $display("FAIL rd%0d_bus: got req=%b we=%b addr=%h want 1 0 00002000",
                                   k, mem_req, mem_we, mem_addr);
            end
            @(negedge clk);
            n_checks++;
            if (d_done !== 1'b1 || d_rdata !== rexp[k]) begin
                n_fail++; $display("FAIL rd%0d_data: got done=%b rdata=%h want 1 %h", k, d_done, d_rdata, rexp[k]);
            end
            d_req = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        int nd, ni;
        nd = 0; ni = 0;
        @(posedge clk); #1;
        ack_delay = 0; rdata_val = 64'h01234567_89ABCDEF;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            if (d_done) nd++;
            if (i_done) ni++;
            if (c == 10) d_req = 1'b0;
        end
        n_checks++;
        if (nd !== 5) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 5", nd); end
        n_checks++;
        if (ni !== 0) begin n_fail++; $display("FAIL b2b_no_fetch: got %0d want 0", ni); end
    endtask

    task automatic test_contention();
        logic [31:0] glog [8];
        int   ng, nd_before, stall_gap, i_done_cyc, d_last_cyc;
        logic prev;
        ng = 0; nd_before = 0; stall_gap = 0; i_done_cyc = -1; d_last_cyc = -1; prev = 1'b0;
        for (int k = 0; k < 8; k++) glog[k] = 32'h0;
        @(posedge clk); #1;
        ack_delay = 0; rdata_val = 64'hCCCCCCCC_DDDDDDDD;
        i_addr = 32'h1000; d_addr = 32'h2000; d_we = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        for (int c = 0; c < 40 && d_last_cyc < 0; c++) begin
            @(negedge clk);
            if (mem_req && !prev && ng < 8) begin glog[ng] = mem_addr; ng++; end
            prev = mem_req;
            if (i_done_cyc < 0) begin
                if (i_done) begin
                    i_done_cyc = c; i_req = 1'b0;
                end else begin
                    if (!i_stall) stall_gap++;
                    if (d_done) nd_before++;
                end
            end else if (d_done) begin
                d_last_cyc = c; d_req = 1'b0;
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        n_checks++;
        if (i_done_cyc !== 10) begin n_fail++; $display("FAIL cont_i_done_cycle: got %0d want 10", i_done_cyc); end
        n_checks++;
        if (nd_before !== 4) begin n_fail++; $display("FAIL cont_data_first: got %0d want 4", nd_before); end
        n_checks++;
        if (stall_gap !== 0) begin n_fail++; $display("FAIL cont_i_stall: got %0d low cycles want 0", stall_gap); end
        n_checks++;
        if (ng !== 6 || glog[0] !== 32'h2000 || glog[1] !== 32'h2000 || glog[2] !== 32'h2000 ||
            glog[3] !== 32'h2000 || glog[4] !== 32'h1000 || glog[5] !== 32'h2000) begin
            n_fail++; $display("FAIL cont_order: got n=%0d %h %h %h %h %h %h want D D D D I D (2000 x4, 1000, 2000)",
                               ng, glog[0], glog[1], glog[2], glog[3], glog[4], glog[5]);
        end
        n_checks++;
        if (d_last_cyc !== 12) begin n_fail++; $display("FAIL cont_d_after: got %0d want 12", d_last_cyc); end
    endtask

    task automatic test_flush();
        int   done_cyc;
        logic seen_new;
        done_cyc = -1; seen_new = 1'b0;
        @(posedge clk); #1;
        ack_delay = 3; rdata_val = 64'hBAD0BAD0_BAD0BAD0;
        i_addr = 32'h3000; i_req = 1'b1;
        @(posedge clk); #1;
        i_flush = 1'b1; i_addr = 32'h3008;
        @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h3000) begin
            n_fail++; $display("FAIL flush_bus_stable: got req=%b addr=%h want 1 00003000", mem_req, mem_addr);
        end
        @(posedge clk); #1;
        i_flush = 1'b0;
        for (int c = 2; c < 30 && done_cyc < 0; c++) begin
            @(negedge clk);
            if (mem_req && mem_addr == 32'h3008) begin
                rdata_val = 64'h600D600D_600D600D; seen_new = 1'b1;
            end
            if (i_done) begin done_cyc = c; i_req = 1'b0; end
        end
        i_req = 1'b0;
        n_checks++;
        if (done_cyc !== 10) begin n_fail++; $display("FAIL flush_done_cycle: got %0d want 10", done_cyc); end
        n_checks++;
        if (seen_new !== 1'b1) begin n_fail++; $display("FAIL flush_new_addr: got %b want 1", seen_new); end
        n_checks++;
        if (i_rdata !== 64'h600D600D_600D600D || i_err !== 1'b0) begin
            n_fail++; $display("FAIL flush_rdata: got %h err=%b want 600d600d600d600d 0", i_rdata, i_err);
        end
        ack_delay = 0;
    endtask

    task automatic test_timeout();
        int          nreq, done_cyc;
        logic        got_err;
        logic [31:0] got_rd;
        for (int s = 0; s < 2; s++) begin
            nreq = 0; done_cyc = -1; got_err = 1'bx; got_rd = 32'hx;
            @(posedge clk); #1;
            ack_en = (s == 1); ack_delay = 254;
            rdata_val = 64'h12345678_9ABCDEF0;
            d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4000;
            for (int c = 0; c < 400 && done_cyc < 0; c++) begin
                @(negedge clk);
                if (mem_req) nreq++;
                if (d_done) begin
                    done_cyc = c; got_err = d_err; got_rd = d_rdata; d_req = 1'b0;
                end
            end
            d_req = 1'b0;
            n_checks++;
            if (nreq !== 255) begin n_fail++; $display("FAIL tmo%0d_req_cycles: got %0d want 255", s, nreq); end
            n_checks++;
            if (done_cyc !== 256) begin n_fail++; $display("FAIL tmo%0d_done_cycle: got %0d want 256", s, done_cyc); end
            n_checks++;
            if (s == 0 && (got_err !== 1'b1 || got_rd !== 32'h0)) begin
                n_fail++; $display("FAIL tmo0_result: got err=%b rdata=%h want 1 00000000", got_err, got_rd);
            end else if (s == 1 && (got_err !== 1'b0 || got_rd !== 32'h12345678)) begin
                n_fail++; $display("FAIL tmo1_ack_wins: got err=%b rdata=%h want 0 12345678", got_err, got_rd);
            end
            @(negedge clk);
            n_checks++;
            if (d_done !== 1'b0 || d_err !== 1'b0) begin
                n_fail++; $display("FAIL tmo%0d_pulse: got done=%b err=%b want 0 0", s, d_done, d_err);
            end
        end
        ack_en = 1'b1; ack_delay = 0;
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        ack_en = 1'b0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h5000; d_wdata = 32'h0F0F0F0F; d_wstrb = 4'hF;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rmid_busy: got req=%b want 1", mem_req); end
        @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b0 || d_done !== 1'b0) begin
            n_fail++; $display("FAIL rmid_drop: got req=%b done=%b want 0 0", mem_req, d_done);
        end
        rst = 1'b0; ack_force = 1'b1; d_req = 1'b0;
        @(negedge clk);
        ack_force = 1'b0;
        n_checks++;
        if (d_done !== 1'b0 || d_err !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++; $display("FAIL rmid_late_ack: got done=%b err=%b req=%b want 0 0 0", d_done, d_err, mem_req);
        end
        @(negedge clk);
        n_checks++;
        if (d_done !== 1'b0 || i_done !== 1'b0) begin
            n_fail++; $display("FAIL rmid_quiet: got ddone=%b idone=%b want 0 0", d_done, i_done);
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rst = 1'b1; i_req = 1'b0; i_addr = 32'h0; i_flush = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_wstrb = 4'h0;
        ack_force = 1'b0; ack_en = 1'b0; ack_delay = 0; rdata_val = 64'h0;
        test_reset();
        test_fetch();
        test_data();
        test_back_to_back();
        test_contention();
        test_flush();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
